// File: rtl/ddr2_pkg.sv
// ddr2_pkg: shared command encodings, scheduler states and alignment helper
// for the DDR2 MCB port scheduler.
package ddr2_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } sched_state_e;

    // Number of low byte-address bits that must be zero for a burst.
    function automatic int align_bits(input int burst_len);
        return $clog2(4 * burst_len);
    endfunction

endpackage

// File: rtl/ddr2_rd_credit.sv
// ddr2_rd_credit: outstanding read-burst counter with sticky underflow flag.
// Simultaneous issue and drain leave the count unchanged.
module ddr2_rd_credit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o,
    output logic       err_underflow_o
);

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 4'd1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == 4'd0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o           = cnt_q;
    assign err_underflow_o = err_q;

endmodule

// File: rtl/ddr2_port_sched.sv
// ddr2_port_sched: round-robin write/read command scheduler for one MCB port.
// Define DDR2_SCHED_STARVE_EN to bound consecutive urgent write wins.
module ddr2_port_sched
    import ddr2_pkg::*;
#(
    parameter int BURST_LEN    = 16,
    parameter int MAX_RD_OUT   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        calib_done,
    input  logic        wr_req,
    input  logic [29:0] wr_addr,
    input  logic        wr_urgent,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    output logic        rd_ack,
    input  logic        rd_burst_done,
    input  logic        p0_cmd_full,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [29:0] p0_cmd_byte_addr,
    output logic [5:0]  p0_cmd_bl_o,
    output logic [3:0]  rd_outstanding,
    output logic        err_misalign,
    output logic        err_underflow
);

    localparam int         AB     = align_bits(BURST_LEN);
    localparam logic [3:0] MAX_RD = 4'(MAX_RD_OUT);

    sched_state_e state_q, state_d;
    logic [29:0]  addr_q, addr_d;
    logic [2:0]   instr_q, instr_d;
    logic         win_rd_q, win_rd_d;
    logic         last_wr_q, last_wr_d;
    logic         err_mis_q, err_mis_d;

    logic wr_el, rd_el, arb_ok, grant, pick_rd;
    logic starved, misalign, rd_inc;

    assign wr_el    = wr_req;
    assign rd_el    = rd_req && (rd_outstanding < MAX_RD);
    assign arb_ok   = (state_q == S_IDLE) && calib_done && !p0_cmd_full;
    assign grant    = arb_ok && (wr_el || rd_el);
    assign misalign = |addr_q[AB-1:0];

    // Under contention: starvation guard, then urgency, then alternate.
    always_comb begin
        pick_rd = rd_el;
        if (wr_el && rd_el) begin
            pick_rd = starved || (!wr_urgent && last_wr_q);
        end
    end

`ifdef DDR2_SCHED_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign starved = (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (pick_rd) begin
                starve_d = '0;
            end else if (rd_el && wr_urgent) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        win_rd_d  = win_rd_q;
        last_wr_d = last_wr_q;
        err_mis_d = err_mis_q;
        p0_cmd_en = 1'b0;
        wr_ack    = 1'b0;
        rd_ack    = 1'b0;
        rd_inc    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d   = S_ISSUE;
                    win_rd_d  = pick_rd;
                    last_wr_d = !pick_rd;
                    addr_d    = pick_rd ? rd_addr : wr_addr;
                    instr_d   = pick_rd ? CMD_RD : CMD_WR;
                end
            end
            S_ISSUE: begin
                // A misaligned burst is acked but never reaches the MCB.
                p0_cmd_en = !misalign;
                wr_ack    = !win_rd_q;
                rd_ack    = win_rd_q;
                rd_inc    = win_rd_q && !misalign;
                if (misalign) begin
                    err_mis_d = 1'b1;
                end
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            instr_q   <= '0;
            win_rd_q  <= 1'b0;
            last_wr_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            win_rd_q  <= win_rd_d;
            last_wr_q <= last_wr_d;
            err_mis_q <= err_mis_d;
        end
    end

    ddr2_rd_credit u_credit (
        .clk             (clk),
        .reset_n         (reset_n),
        .inc_i           (rd_inc),
        .dec_i           (rd_burst_done),
        .cnt_o           (rd_outstanding),
        .err_underflow_o (err_underflow)
    );

    assign p0_cmd_instr     = instr_q;
    assign p0_cmd_byte_addr = addr_q;
    assign p0_cmd_bl_o      = 6'(BURST_LEN - 1);
    assign err_misalign     = err_mis_q;

endmodule

// File: tb/tb_ddr2_port_sched.sv
// tb_ddr2_port_sched: directed and randomized checks of ddr2_port_sched
// against a command-level scheduling model.
module tb_ddr2_port_sched;

    localparam int BL    = 16;
    localparam int MAXRD = 4;
    localparam int SLIM  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        calib_done = 1'b0;
    logic        wr_req = 1'b0;
    logic [29:0] wr_addr = '0;
    logic        wr_urgent = 1'b0;
    logic        wr_ack;
    logic        rd_req = 1'b0;
    logic [29:0] rd_addr = '0;
    logic        rd_ack;
    logic        rd_burst_done = 1'b0;
    logic        p0_cmd_full = 1'b0;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [29:0] p0_cmd_byte_addr;
    logic [5:0]  p0_cmd_bl_o;
    logic [3:0]  rd_outstanding;
    logic        err_misalign;
    logic        err_underflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_on = 1'b0;

    ddr2_port_sched #(.BURST_LEN(BL), .MAX_RD_OUT(MAXRD), .STARVE_LIMIT(SLIM)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .calib_done       (calib_done),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_urgent        (wr_urgent),
        .wr_ack           (wr_ack),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_ack           (rd_ack),
        .rd_burst_done    (rd_burst_done),
        .p0_cmd_full      (p0_cmd_full),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_bl_o      (p0_cmd_bl_o),
        .rd_outstanding   (rd_outstanding),
        .err_misalign     (err_misalign),
        .err_underflow    (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [29:0] rnd_addr();
        logic [29:0] a;
        a = 30'($urandom);
        if ($urandom_range(0, 15) != 0) a[5:0] = 6'd0;
        return a;
    endfunction

    // Command-level model: a grant occupies the channel for three edges,
    // its effects on the read credit and error flag land one edge later.
    logic        m_en = 0, m_wack = 0, m_rack = 0;
    logic        m_err_mis = 0, m_err_und = 0, m_last_wr = 0;
    logic        m_pend_inc = 0, m_pend_bad = 0;
    logic [2:0]  m_instr = '0;
    logic [29:0] m_addr = '0;
    int          m_cnt = 0, m_hold = 0, m_starve = 0;

    always @(posedge clk or negedge reset_n) begin
        int cnt_pre;
        logic we, re, rd, bad, starved;
        logic [29:0] a;
        if (!reset_n) begin
            m_en = 0; m_wack = 0; m_rack = 0;
            m_err_mis = 0; m_err_und = 0; m_last_wr = 0;
            m_pend_inc = 0; m_pend_bad = 0;
            m_instr = '0; m_addr = '0;
            m_cnt = 0; m_hold = 0; m_starve = 0;
        end else begin
            cnt_pre = m_cnt;
            if (m_pend_inc && !rd_burst_done) m_cnt++;
            else if (!m_pend_inc && rd_burst_done) begin
                if (m_cnt == 0) m_err_und = 1;
                else m_cnt--;
            end
            if (m_pend_bad) m_err_mis = 1;
            m_pend_inc = 0; m_pend_bad = 0;
            m_en = 0; m_wack = 0; m_rack = 0;
            if (m_hold > 0) begin
                m_hold--;
            end else if (calib_done && !p0_cmd_full) begin
                we = wr_req;
                re = rd_req && (cnt_pre < MAXRD);
`ifdef DDR2_SCHED_STARVE_EN
                starved = (m_starve >= SLIM);
`else
                starved = 0;
`endif
                if (we || re) begin
                    if (we && re) rd = starved || (!wr_urgent && m_last_wr);
                    else rd = re;
                    a = rd ? rd_addr : wr_addr;
                    bad = (32'(a) % (4 * BL)) != 0;
                    m_addr = a;
                    m_instr = rd ? 3'b001 : 3'b000;
                    m_last_wr = !rd;
                    m_en = !bad;
                    m_wack = !rd;
                    m_rack = rd;
                    m_pend_inc = rd && !bad;
                    m_pend_bad = bad;
                    m_hold = 2;
                    if (rd) m_starve = 0;
                    else if (re && wr_urgent) m_starve++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmd_en", 32'(p0_cmd_en), 32'(m_en));
            check("wr_ack", 32'(wr_ack), 32'(m_wack));
            check("rd_ack", 32'(rd_ack), 32'(m_rack));
            check("instr", 32'(p0_cmd_instr), 32'(m_instr));
            check("addr", 32'(p0_cmd_byte_addr), 32'(m_addr));
            check("rd_out", 32'(rd_outstanding), 32'(m_cnt));
            check("err_mis", 32'(err_misalign), 32'(m_err_mis));
            check("err_und", 32'(err_underflow), 32'(m_err_und));
        end
    end

    initial begin
        int n, acks, cyc;
        int seq[$];
        int at[$];
        #2 reset_n = 1'b0;
        cmp_on = 1'b1;
        repeat (3) tick();
        check("rst_en", 32'(p0_cmd_en), 32'd0);
        check("rst_cnt", 32'(rd_outstanding), 32'd0);
        check("bl", 32'(p0_cmd_bl_o), 32'd15);
        reset_n = 1'b1;
        calib_done = 1'b1;
        tick();

        // single aligned write
        wr_req = 1; wr_addr = 30'h200040;
        tick();
        check("t1_en", 32'(p0_cmd_en), 32'd1);
        check("t1_instr", 32'(p0_cmd_instr), 32'd0);
        check("t1_addr", 32'(p0_cmd_byte_addr), 32'h200040);
        check("t1_wack", 32'(wr_ack), 32'd1);
        wr_req = 0;
        tick();
        check("t1_en_off", 32'(p0_cmd_en), 32'd0);

        // alternation without urgency
        do_reset();
        wr_req = 1; wr_addr = 30'h1000; rd_req = 1; rd_addr = 30'h2000;
        seq.delete(); at.delete();
        for (int i = 0; i < 30 && seq.size() < 4; i++) begin
            tick();
            if (p0_cmd_en) begin
                seq.push_back(int'(p0_cmd_instr));
                at.push_back(i);
            end
        end
        check("t2_n", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++) begin
            check("t2_instr", 32'(seq[i]), 32'(i % 2));
            if (i > 0) check("t2_gap", 32'(at[i] - at[i-1]), 32'd3);
        end
        wr_req = 0; rd_req = 0;

        // read credit limit
        do_reset();
        rd_req = 1; rd_addr = 30'h3000;
        n = 0;
        repeat (30) begin
            tick();
            if (p0_cmd_en && p0_cmd_instr == 3'b001) n++;
        end
        check("t3_reads", 32'(n), 32'd4);
        check("t3_out", 32'(rd_outstanding), 32'd4);
        rd_burst_done = 1;
        tick();
        rd_burst_done = 0;
        n = 0;
        repeat (20) begin
            tick();
            if (p0_cmd_en && p0_cmd_instr == 3'b001) n++;
        end
        check("t3_more", 32'(n), 32'd1);
        check("t3_out2", 32'(rd_outstanding), 32'd4);
        rd_req = 0;

        // misaligned write
        do_reset();
        wr_req = 1; wr_addr = 30'h200044;
        tick();
        check("t4_en", 32'(p0_cmd_en), 32'd0);
        check("t4_wack", 32'(wr_ack), 32'd1);
        wr_req = 0;
        tick();
        check("t4_err", 32'(err_misalign), 32'd1);
        repeat (10) tick();
        check("t4_sticky", 32'(err_misalign), 32'd1);
        do_reset();
        check("t4_clr", 32'(err_misalign), 32'd0);

        // command FIFO full blocks arbitration
        p0_cmd_full = 1; wr_req = 1; wr_addr = 30'h4000; rd_req = 1; rd_addr = 30'h5000;
        n = 0;
        repeat (10) begin
            tick();
            if (p0_cmd_en) n++;
        end
        check("t5_none", 32'(n), 32'd0);
        p0_cmd_full = 0;
        tick();
        check("t5_en", 32'(p0_cmd_en), 32'd1);
        check("t5_instr", 32'(p0_cmd_instr), 32'd0);
        wr_req = 0; rd_req = 0;

        // urgent writes against a waiting read
        do_reset();
        wr_req = 1; wr_addr = 30'h6000; rd_req = 1; rd_addr = 30'h7000; wr_urgent = 1;
        seq.delete();
        for (int i = 0; i < 60 && seq.size() < 9; i++) begin
            tick();
            if (p0_cmd_en) seq.push_back(int'(p0_cmd_instr));
        end
        check("t6_n", 32'(seq.size()), 32'd9);
        for (int i = 0; i < seq.size(); i++) begin
`ifdef DDR2_SCHED_STARVE_EN
            check("t6_instr", 32'(seq[i]), (i == 8) ? 32'd1 : 32'd0);
`else
            check("t6_instr", 32'(seq[i]), 32'd0);
`endif
        end
        wr_req = 0; rd_req = 0; wr_urgent = 0;

        // asynchronous reset while a read is being issued
        do_reset();
        rd_req = 1; rd_addr = 30'h8000;
        acks = 0;
        for (int i = 0; i < 20 && acks < 2; i++) begin
            tick();
            if (rd_ack) acks++;
        end
        check("t7_acks", 32'(acks), 32'd2);
        reset_n = 0;
        #1;
        check("t7_en", 32'(p0_cmd_en), 32'd0);
        check("t7_rack", 32'(rd_ack), 32'd0);
        check("t7_out", 32'(rd_outstanding), 32'd0);
        tick();
        reset_n = 1;
        tick();
        check("t7_restart", 32'(p0_cmd_en), 32'd1);
        rd_req = 0;

        // drain with nothing outstanding
        do_reset();
        rd_burst_done = 1;
        tick();
        rd_burst_done = 0;
        tick();
        check("t8_und", 32'(err_underflow), 32'd1);
        check("t8_out", 32'(rd_outstanding), 32'd0);

        // randomized traffic
        do_reset();
        cyc = 0;
        while (cyc < 4000) begin
            if (m_wack) begin
                wr_req = 1'($urandom_range(0, 1));
                wr_addr = rnd_addr();
            end else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1;
                wr_addr = rnd_addr();
            end
            if (m_rack) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_addr = rnd_addr();
            end else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1;
                rd_addr = rnd_addr();
            end
            wr_urgent = ($urandom_range(0, 2) == 0);
            p0_cmd_full = ($urandom_range(0, 4) == 0);
            calib_done = ($urandom_range(0, 15) != 0);
            rd_burst_done = (m_cnt > 0) && ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
        end
        wr_req = 0; rd_req = 0; rd_burst_done = 0;
        repeat (4) tick();
        cmp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
